// File: rtl/text_draw_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : text_draw_seq_if
// Brief    : Request, glyph-lookup and pixel-write signals of text_draw_seq.
// Revision : 1.0
// ============================================================================
interface text_draw_seq_if #(
  parameter int MAX_CHARS = 8
) ();
  logic                   start;
  logic [7:0]             str_x;
  logic [7:0]             str_y;
  logic [3:0]             str_len;
  logic [6*MAX_CHARS-1:0] str_codes;
  logic                   busy;
  logic                   done;
  logic [5:0]             glyph_code;
  logic [7:0]             glyph_dx;
  logic [7:0]             glyph_dy;
  logic [5:0]             glyph_colour;
  logic                   glyph_en;
  logic [7:0]             plot_x;
  logic [7:0]             plot_y;
  logic [5:0]             plot_colour;
  logic                   plot;
  logic                   plot_ready;

  modport master (
    output start, str_x, str_y, str_len, str_codes, glyph_colour, glyph_en, plot_ready,
    input  busy, done, glyph_code, glyph_dx, glyph_dy, plot_x, plot_y, plot_colour, plot
  );

  modport slave (
    input  start, str_x, str_y, str_len, str_codes, glyph_colour, glyph_en, plot_ready,
    output busy, done, glyph_code, glyph_dx, glyph_dy, plot_x, plot_y, plot_colour, plot
  );
endinterface
`default_nettype wire

// File: rtl/text_draw_seq.sv
`default_nettype none
// ============================================================================
// Module   : text_draw_seq
// Brief    : Walks the pixels of a glyph string and emits frame-buffer writes.
// Revision : 1.0
// ============================================================================
module text_draw_seq #(
  parameter int         CELL_W    = 8,
  parameter int         CELL_H    = 10,
  parameter int         MAX_CHARS = 8,
  parameter int         FILL_BG   = 0,
  parameter logic [5:0] BG_COLOUR = 6'b000000
) (
  input  wire logic      clk,
  input  wire logic      reset,
  text_draw_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int         CODES_W     = 6 * MAX_CHARS;
  localparam logic [7:0] C_CELL_W    = 8'(CELL_W);
  localparam logic [7:0] C_LAST_DX   = 8'(CELL_W - 1);
  localparam logic [7:0] C_LAST_DY   = 8'(CELL_H - 1);
  localparam logic [7:0] C_MAX_CHARS = 8'(MAX_CHARS);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [7:0]         r_cell_x;
  logic [7:0]         r_str_y;
  logic [7:0]         r_dx;
  logic [7:0]         r_dy;
  logic [7:0]         r_idx;
  logic [7:0]         r_n;
  logic [CODES_W-1:0] r_codes;
  logic [7:0]         r_plot_x;
  logic [7:0]         r_plot_y;
  logic [5:0]         r_plot_colour;

  logic [7:0] w_n;
  logic       w_take;
  logic       w_adv;
  logic       w_last_dx;
  logic       w_last_dy;
  logic       w_last_pix;
  logic       w_busy;
  logic       w_done;
  logic       w_plot;

  assign w_n        = ({4'd0, bus.str_len} > C_MAX_CHARS) ? C_MAX_CHARS : {4'd0, bus.str_len};
  assign w_take     = bus.glyph_en || (FILL_BG != 0);
  assign w_last_dx  = (r_dx == C_LAST_DX);
  assign w_last_dy  = (r_dy == C_LAST_DY);
  assign w_last_pix = w_last_dx && w_last_dy && (r_idx == r_n - 8'd1);
  assign w_adv      = ((r_state == S_LOOKUP) && !w_take) ||
                      ((r_state == S_EMIT) && bus.plot_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = (w_n == 8'd0) ? S_DONE : S_LOOKUP;
      S_LOOKUP: if (w_take) w_state_nxt = S_EMIT;
                else        w_state_nxt = w_last_pix ? S_DONE : S_LOOKUP;
      S_EMIT:   if (bus.plot_ready) w_state_nxt = w_last_pix ? S_DONE : S_LOOKUP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b1;
    w_done = 1'b0;
    w_plot = 1'b0;
    case (r_state)
      S_IDLE:  w_busy = 1'b0;
      S_EMIT:  w_plot = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // The current cell's code always sits in the low six bits; moving to the
  // next cell shifts the latched codes down and bumps the cell x-origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cell_x      <= 8'd0;
      r_str_y       <= 8'd0;
      r_dx          <= 8'd0;
      r_dy          <= 8'd0;
      r_idx         <= 8'd0;
      r_n           <= 8'd0;
      r_codes       <= '0;
      r_plot_x      <= 8'd0;
      r_plot_y      <= 8'd0;
      r_plot_colour <= 6'd0;
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_cell_x <= bus.str_x;
        r_str_y  <= bus.str_y;
        r_codes  <= bus.str_codes;
        r_n      <= w_n;
        r_idx    <= 8'd0;
        r_dx     <= 8'd0;
        r_dy     <= 8'd0;
      end
      if ((r_state == S_LOOKUP) && w_take) begin
        r_plot_x      <= r_cell_x + r_dx;
        r_plot_y      <= r_str_y + r_dy;
        r_plot_colour <= bus.glyph_en ? bus.glyph_colour : BG_COLOUR;
      end
      if (w_adv) begin
        if (!w_last_dx) begin
          r_dx <= r_dx + 8'd1;
        end else begin
          r_dx <= 8'd0;
          if (!w_last_dy) begin
            r_dy <= r_dy + 8'd1;
          end else begin
            r_dy     <= 8'd0;
            r_idx    <= r_idx + 8'd1;
            r_cell_x <= r_cell_x + C_CELL_W;
            r_codes  <= r_codes >> 6;
          end
        end
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.plot        = w_plot;
  assign bus.plot_x      = r_plot_x;
  assign bus.plot_y      = r_plot_y;
  assign bus.plot_colour = r_plot_colour;
  assign bus.glyph_code  = r_codes[5:0];
  assign bus.glyph_dx    = r_dx;
  assign bus.glyph_dy    = r_dy;
endmodule
`default_nettype wire

// File: tb/tb_text_draw_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_draw_seq
// Brief    : Directed checks of text_draw_seq against an "E" glyph decoder.
// Revision : 1.0
// ============================================================================
module tb_text_draw_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  text_draw_seq_if #(.MAX_CHARS(8)) bus_a ();
  text_draw_seq_if #(.MAX_CHARS(8)) bus_b ();

  text_draw_seq #(.FILL_BG(0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  text_draw_seq #(.FILL_BG(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // "E": column 2 on every row, columns 2-7 on rows 0, 4 and 9.
  function automatic logic e_lit(input logic [7:0] dx, input logic [7:0] dy);
    return (dx == 8'd2 && dy <= 8'd9) ||
           (dx >= 8'd2 && dx <= 8'd7 && (dy == 8'd0 || dy == 8'd4 || dy == 8'd9));
  endfunction

  always_comb begin
    bus_a.glyph_en     = e_lit(bus_a.glyph_dx, bus_a.glyph_dy);
    bus_a.glyph_colour = 6'h3F ^ bus_a.glyph_code;
    bus_b.glyph_en     = e_lit(bus_b.glyph_dx, bus_b.glyph_dy);
    bus_b.glyph_colour = 6'h3F ^ bus_b.glyph_code;
  end

  logic [7:0] wa_x [0:1023];
  logic [7:0] wa_y [0:1023];
  logic [5:0] wa_c [0:1023];
  int         na_plot = 0, na_busy = 0, na_done = 0, stall_err = 0;
  logic       pa_plot = 1'b0, pa_ready = 1'b0;
  logic [7:0] pa_x, pa_y;
  logic [5:0] pa_c;

  always @(negedge clk) begin
    if (pa_plot && !pa_ready &&
        (bus_a.plot !== 1'b1 || bus_a.plot_x !== pa_x || bus_a.plot_y !== pa_y ||
         bus_a.plot_colour !== pa_c))
      stall_err <= stall_err + 1;
    if (bus_a.plot === 1'b1 && bus_a.plot_ready === 1'b1) begin
      wa_x[na_plot % 1024] <= bus_a.plot_x;
      wa_y[na_plot % 1024] <= bus_a.plot_y;
      wa_c[na_plot % 1024] <= bus_a.plot_colour;
      na_plot <= na_plot + 1;
    end
    if (bus_a.busy === 1'b1) na_busy <= na_busy + 1;
    if (bus_a.done === 1'b1) na_done <= na_done + 1;
    pa_plot  <= (bus_a.plot === 1'b1);
    pa_ready <= (bus_a.plot_ready === 1'b1);
    pa_x     <= bus_a.plot_x;
    pa_y     <= bus_a.plot_y;
    pa_c     <= bus_a.plot_colour;
  end

  int         nb_plot = 0, nb_bg = 0, nb_fg = 0, nb_busy = 0, nb_done = 0;
  logic [7:0] nb_first_x, nb_first_y, nb_last_x, nb_last_y;

  always @(negedge clk) begin
    if (bus_b.plot === 1'b1 && bus_b.plot_ready === 1'b1) begin
      if (nb_plot == 0) begin
        nb_first_x <= bus_b.plot_x;
        nb_first_y <= bus_b.plot_y;
      end
      nb_last_x <= bus_b.plot_x;
      nb_last_y <= bus_b.plot_y;
      nb_plot   <= nb_plot + 1;
      if (bus_b.plot_colour == 6'h00) nb_bg <= nb_bg + 1;
      if (bus_b.plot_colour == 6'h3F) nb_fg <= nb_fg + 1;
    end
    if (bus_b.busy === 1'b1) nb_busy <= nb_busy + 1;
    if (bus_b.done === 1'b1) nb_done <= nb_done + 1;
  end

  task automatic start_a(input logic [7:0] x, input logic [7:0] y, input logic [3:0] len,
                         input logic [47:0] codes);
    @(posedge clk); #1;
    bus_a.str_x = x; bus_a.str_y = y; bus_a.str_len = len; bus_a.str_codes = codes;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
  endtask

  task automatic wait_a_idle(output bit timeout);
    int k = 0;
    while (bus_a.busy === 1'b1 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    timeout = (bus_a.busy === 1'b1);
  endtask

  task automatic test_reset;
    n_checks++;
    if ({bus_a.busy, bus_a.done, bus_a.plot, bus_b.busy, bus_b.done, bus_b.plot} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {bus_a.busy, bus_a.done, bus_a.plot, bus_b.busy, bus_b.done, bus_b.plot});
    end
    n_checks++;
    if ({bus_a.plot_x, bus_a.plot_y, bus_a.plot_colour} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_plot_regs: got %h, expected 0",
               {bus_a.plot_x, bus_a.plot_y, bus_a.plot_colour});
    end
    n_checks++;
    if ({bus_a.glyph_code, bus_a.glyph_dx, bus_a.glyph_dy} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_glyph_regs: got %h, expected 0",
               {bus_a.glyph_code, bus_a.glyph_dx, bus_a.glyph_dy});
    end
  endtask

  // Shared checks for a single "E" at (10,20) with code 0 on DUT A.
  task automatic check_single_e(input string tag, input int p0, input int b0, input int d0,
                                input int exp_busy);
    int sx = 0, sy = 0, bad_c = 0;
    for (int i = p0; i < na_plot; i++) begin
      sx += int'(wa_x[i % 1024]);
      sy += int'(wa_y[i % 1024]);
      if (wa_c[i % 1024] != 6'h3F) bad_c++;
    end
    n_checks++;
    if (na_plot - p0 != 25) begin
      n_fail++; $display("FAIL %s_plots: got %0d, expected 25", tag, na_plot - p0);
    end
    n_checks++;
    if (wa_x[p0 % 1024] !== 8'd12 || wa_y[p0 % 1024] !== 8'd20) begin
      n_fail++; $display("FAIL %s_first: got (%0d,%0d), expected (12,20)", tag,
                         wa_x[p0 % 1024], wa_y[p0 % 1024]);
    end
    n_checks++;
    if (wa_x[(na_plot - 1) % 1024] !== 8'd17 || wa_y[(na_plot - 1) % 1024] !== 8'd29) begin
      n_fail++; $display("FAIL %s_last: got (%0d,%0d), expected (17,29)", tag,
                         wa_x[(na_plot - 1) % 1024], wa_y[(na_plot - 1) % 1024]);
    end
    n_checks++;
    if (sx != 345 || sy != 610) begin
      n_fail++; $display("FAIL %s_coord_sums: got x=%0d y=%0d, expected x=345 y=610", tag, sx, sy);
    end
    n_checks++;
    if (bad_c != 0) begin
      n_fail++; $display("FAIL %s_colour: got %0d off-colour writes, expected 0", tag, bad_c);
    end
    n_checks++;
    if (na_busy - b0 != exp_busy) begin
      n_fail++; $display("FAIL %s_busy: got %0d, expected %0d", tag, na_busy - b0, exp_busy);
    end
    n_checks++;
    if (na_done - d0 != 1) begin
      n_fail++; $display("FAIL %s_done: got %0d, expected 1", tag, na_done - d0);
    end
  endtask

  task automatic test_single_e;
    int p0 = na_plot, b0 = na_busy, d0 = na_done;
    bit to;
    start_a(8'd10, 8'd20, 4'd1, 48'd0);
    wait_a_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: got busy, expected idle"); end
    check_single_e("single", p0, b0, d0, 106);
  endtask

  task automatic test_fill_bg;
    int k = 0;
    @(posedge clk); #1;
    bus_b.str_x = 8'd10; bus_b.str_y = 8'd20; bus_b.str_len = 4'd1; bus_b.str_codes = 48'd0;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    while (bus_b.busy === 1'b1 && k < 3000) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (nb_plot != 80 || nb_bg != 55 || nb_fg != 25) begin
      n_fail++; $display("FAIL fill_counts: got plots=%0d bg=%0d fg=%0d, expected 80/55/25",
                         nb_plot, nb_bg, nb_fg);
    end
    n_checks++;
    if (nb_first_x !== 8'd10 || nb_first_y !== 8'd20 || nb_last_x !== 8'd17 || nb_last_y !== 8'd29) begin
      n_fail++; $display("FAIL fill_ends: got (%0d,%0d)..(%0d,%0d), expected (10,20)..(17,29)",
                         nb_first_x, nb_first_y, nb_last_x, nb_last_y);
    end
    n_checks++;
    if (nb_busy != 161 || nb_done != 1) begin
      n_fail++; $display("FAIL fill_busy_done: got busy=%0d done=%0d, expected 161/1", nb_busy, nb_done);
    end
  endtask

  task automatic test_empty;
    int p0 = na_plot;
    @(posedge clk); #1;
    bus_a.str_x = 8'd10; bus_a.str_y = 8'd20; bus_a.str_len = 4'd0; bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    n_checks++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b1) begin
      n_fail++; $display("FAIL empty_done: got done=%b busy=%b, expected 1/1", bus_a.done, bus_a.busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || na_plot != p0) begin
      n_fail++; $display("FAIL empty_after: got done=%b busy=%b plots=%0d, expected 0/0/0",
                         bus_a.done, bus_a.busy, na_plot - p0);
    end
  endtask

  task automatic test_overflow_wrap;
    int p0 = na_plot, b0 = na_busy, d0 = na_done, zero_x = 0, last_cell = 0;
    logic [47:0] codes;
    bit to;
    for (int i = 0; i < 8; i++) codes[6*i +: 6] = 6'(i + 1);
    start_a(8'd250, 8'd100, 4'd12, codes);
    wait_a_idle(to);
    for (int i = p0; i < na_plot; i++) begin
      if (wa_x[i % 1024] == 8'd0) zero_x++;
      if (wa_c[i % 1024] == 6'h37) last_cell++;
    end
    n_checks++;
    if (to || na_plot - p0 != 200) begin
      n_fail++; $display("FAIL overflow_plots: got %0d, expected 200", na_plot - p0);
    end
    n_checks++;
    if (wa_x[p0 % 1024] !== 8'd252 || wa_y[p0 % 1024] !== 8'd100 || wa_c[p0 % 1024] !== 6'h3E) begin
      n_fail++; $display("FAIL overflow_first: got (%0d,%0d,%h), expected (252,100,3e)",
                         wa_x[p0 % 1024], wa_y[p0 % 1024], wa_c[p0 % 1024]);
    end
    n_checks++;
    if (wa_x[(na_plot - 1) % 1024] !== 8'd57 || wa_y[(na_plot - 1) % 1024] !== 8'd109 ||
        wa_c[(na_plot - 1) % 1024] !== 6'h37) begin
      n_fail++; $display("FAIL overflow_last: got (%0d,%0d,%h), expected (57,109,37)",
                         wa_x[(na_plot - 1) % 1024], wa_y[(na_plot - 1) % 1024],
                         wa_c[(na_plot - 1) % 1024]);
    end
    n_checks++;
    if (zero_x != 3 || last_cell != 25) begin
      n_fail++; $display("FAIL overflow_wrap: got x0=%0d cell7=%0d, expected 3/25", zero_x, last_cell);
    end
    n_checks++;
    if (na_busy - b0 != 841 || na_done - d0 != 1) begin
      n_fail++; $display("FAIL overflow_busy_done: got %0d/%0d, expected 841/1", na_busy - b0, na_done - d0);
    end
  endtask

  task automatic test_stall;
    int p0 = na_plot, b0 = na_busy, d0 = na_done, s0 = stall_err, k = 0;
    bit to;
    start_a(8'd10, 8'd20, 4'd1, 48'd0);
    while (bus_a.plot !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    bus_a.plot_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.plot !== 1'b1 || bus_a.plot_x !== 8'd12 || bus_a.plot_y !== 8'd20) begin
      n_fail++; $display("FAIL stall_hold: got plot=%b (%0d,%0d), expected 1 (12,20)",
                         bus_a.plot, bus_a.plot_x, bus_a.plot_y);
    end
    bus_a.plot_ready = 1'b1;
    wait_a_idle(to);
    n_checks++;
    if (to || stall_err != s0) begin
      n_fail++; $display("FAIL stall_stable: got %0d glitches, expected 0", stall_err - s0);
    end
    check_single_e("stall", p0, b0, d0, 111);
  endtask

  task automatic test_start_ignored;
    int p0 = na_plot, b0 = na_busy, d0 = na_done;
    bit to;
    start_a(8'd10, 8'd20, 4'd1, 48'd0);
    repeat (7) @(posedge clk);
    #1;
    bus_a.str_x = 8'd0; bus_a.str_len = 4'd0; bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    wait_a_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL ignore_timeout: got busy, expected idle"); end
    check_single_e("ignore", p0, b0, d0, 106);
  endtask

  task automatic test_reset_mid;
    int p0 = na_plot, p1, d1, k = 0;
    bit to;
    start_a(8'd10, 8'd20, 4'd1, 48'd0);
    while (na_plot - p0 < 10 && k < 500) begin @(posedge clk); #1; k++; end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_a.plot !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.plot_x !== 8'd0 || bus_a.glyph_dx !== 8'd0) begin
      n_fail++; $display("FAIL midreset_state: got plot=%b busy=%b x=%0d dx=%0d, expected 0/0/0/0",
                         bus_a.plot, bus_a.busy, bus_a.plot_x, bus_a.glyph_dx);
    end
    reset = 1'b0;
    p1 = na_plot;
    d1 = na_done;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (na_plot != p1 || na_done != d1 || bus_a.busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: got plots=%0d done=%0d, expected 0/0",
                         na_plot - p1, na_done - d1);
    end
    p1 = na_plot;
    start_a(8'd10, 8'd20, 4'd1, 48'd0);
    wait_a_idle(to);
    check_single_e("restart", p1, na_busy - 106 + (to ? 0 : 0), d1, 106);
  endtask

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.str_x = 8'd0; bus_a.str_y = 8'd0; bus_a.str_len = 4'd0;
    bus_a.str_codes = 48'd0; bus_a.plot_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.str_x = 8'd0; bus_b.str_y = 8'd0; bus_b.str_len = 4'd0;
    bus_b.str_codes = 48'd0; bus_b.plot_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_single_e();
    test_fill_bg();
    test_empty();
    test_overflow_wrap();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
